// File: rtl/config_manager_seq_uc.sv
// Purpose: sequences reception of NUM_FIELDS config fields into the register bank,
//          with parity retries (NACK), a per-field timeout and an abort path.
// Latency: start -> first load enable 1 cycle; minimum sequence is 1+NUM_FIELDS+1
//          cycles from start acceptance to pronto. All outputs are registered.
// Backpressure: none; fim_recepcao_config is a qualified pulse and is never stalled.
//          A start request is accepted only in IDLE.
//
// Ports:
//   clock, reset (async, active-low)
//   receber_config      start request (IDLE only)
//   fim_recepcao_config field-complete pulse, qualifies parity_config_ok
//   abort_config        cancel an in-progress sequence
//   load_field          one-hot load enable for the field being received
//   field_idx           index of the field being received
//   nack_config         one-cycle retransmission request after bad parity
//   busy_config         high while receiving or requesting retransmission
//   pronto_config       end-of-sequence pulse (success or error)
//   erro_config         error pulse, coincident with pronto_config
//   erro_code           00 none, 01 parity, 10 timeout, 11 abort (held until next start)
//   retry_cnt           retransmissions used on the current field

module config_manager_seq_uc #(
  parameter int NUM_FIELDS     = 5,
  parameter int MAX_RETRIES    = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int IDX_W          = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1,
  parameter int TMO_W          = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1,
  parameter int RTY_W          = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  receber_config,
  input  logic                  fim_recepcao_config,
  input  logic                  parity_config_ok,
  input  logic                  abort_config,
  output logic [NUM_FIELDS-1:0] load_field,
  output logic [IDX_W-1:0]      field_idx,
  output logic                  nack_config,
  output logic                  busy_config,
  output logic                  pronto_config,
  output logic                  erro_config,
  output logic [1:0]            erro_code,
  output logic [RTY_W-1:0]      retry_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RECEIVE = 3'd1,
    S_NACK    = 3'd2,
    S_DONE    = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  localparam logic [1:0] E_NONE    = 2'b00;
  localparam logic [1:0] E_PARITY  = 2'b01;
  localparam logic [1:0] E_TIMEOUT = 2'b10;
  localparam logic [1:0] E_ABORT   = 2'b11;

  // A zero timeout disables the timer entirely; it then never counts.
  localparam bit               TMO_EN    = (TIMEOUT_CYCLES > 0);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_FIELDS - 1);
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRIES);

  // State and counters
  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        field_idx_q, field_idx_d;
  logic [RTY_W-1:0]        retry_cnt_q, retry_cnt_d;
  logic [TMO_W-1:0]        timer_q, timer_d;
  logic [1:0]              erro_code_q, erro_code_d;

  // Registered Moore outputs, decoded from the next state so they line up
  // with state_q without any input-to-output combinational path.
  logic [NUM_FIELDS-1:0]   load_field_q, load_field_d;
  logic                    nack_q, nack_d;
  logic                    busy_q, busy_d;
  logic                    pronto_q, pronto_d;
  logic                    erro_q, erro_d;

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    field_idx_d = field_idx_q;
    retry_cnt_d = retry_cnt_q;
    timer_d     = timer_q;
    erro_code_d = erro_code_q;

    case (state_q)
      S_IDLE: begin
        // field_idx / retry_cnt / erro_code keep the last sequence's values
        // here so software can inspect where a sequence ended.
        if (receber_config) begin
          state_d     = S_RECEIVE;
          field_idx_d = '0;
          retry_cnt_d = '0;
          timer_d     = '0;
          erro_code_d = E_NONE;
        end
      end

      S_RECEIVE: begin
        // Priority: abort, then field completion, then timeout. A field that
        // finishes on the very cycle the timer expires is accepted.
        if (abort_config) begin
          state_d     = S_ERROR;
          erro_code_d = E_ABORT;
        end else if (fim_recepcao_config) begin
          if (parity_config_ok) begin
            if (field_idx_q == IDX_LAST) begin
              state_d = S_DONE;
            end else begin
              field_idx_d = field_idx_q + IDX_W'(1);
              retry_cnt_d = '0;
              timer_d     = '0;
            end
          end else if (retry_cnt_q == RTY_LIMIT) begin
            state_d     = S_ERROR;
            erro_code_d = E_PARITY;
          end else begin
            state_d     = S_NACK;
            retry_cnt_d = retry_cnt_q + RTY_W'(1);
            timer_d     = '0;
          end
        end else if (TMO_EN && (timer_q == TMO_LAST)) begin
          state_d     = S_ERROR;
          erro_code_d = E_TIMEOUT;
        end else if (TMO_EN) begin
          timer_d = timer_q + TMO_W'(1);
        end
      end

      S_NACK: begin
        // Single-cycle retransmission request; a stray fim here is dropped.
        if (abort_config) begin
          state_d     = S_ERROR;
          erro_code_d = E_ABORT;
        end else begin
          state_d = S_RECEIVE;
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;

      // Recover from any illegal encoding.
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Output decode (from next state)
  // ------------------------------------------------------------------
  always_comb begin
    load_field_d = '0;
    if (state_d == S_RECEIVE) begin
      for (int i = 0; i < NUM_FIELDS; i++) begin
        load_field_d[i] = (field_idx_d == IDX_W'(i));
      end
    end
    nack_d   = (state_d == S_NACK);
    busy_d   = (state_d == S_RECEIVE) || (state_d == S_NACK);
    pronto_d = (state_d == S_DONE) || (state_d == S_ERROR);
    erro_d   = (state_d == S_ERROR);
  end

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      field_idx_q  <= '0;
      retry_cnt_q  <= '0;
      timer_q      <= '0;
      erro_code_q  <= E_NONE;
      load_field_q <= '0;
      nack_q       <= 1'b0;
      busy_q       <= 1'b0;
      pronto_q     <= 1'b0;
      erro_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      field_idx_q  <= field_idx_d;
      retry_cnt_q  <= retry_cnt_d;
      timer_q      <= timer_d;
      erro_code_q  <= erro_code_d;
      load_field_q <= load_field_d;
      nack_q       <= nack_d;
      busy_q       <= busy_d;
      pronto_q     <= pronto_d;
      erro_q       <= erro_d;
    end
  end

  assign load_field    = load_field_q;
  assign field_idx     = field_idx_q;
  assign nack_config   = nack_q;
  assign busy_config   = busy_q;
  assign pronto_config = pronto_q;
  assign erro_config   = erro_q;
  assign erro_code     = erro_code_q;
  assign retry_cnt     = retry_cnt_q;

endmodule

// File: tb/tb_config_manager_seq_uc.sv
// Bench for config_manager_seq_uc: a 5-field/2-retry/16-cycle-timeout instance and
// a 1-field/0-retry/no-timeout instance share the same inputs. A directed table,
// hand sequences and random traffic are checked against a behavioural model.
module tb_config_manager_seq_uc;

  logic clock;
  logic reset;
  logic receber, fim, pok, abrt;

  logic [4:0] load0;
  logic [2:0] idx0;
  logic [1:0] rty0;
  logic [1:0] code0;
  logic       nack0, busy0, pronto0, erro0;

  logic [0:0] load1;
  logic [0:0] idx1;
  logic [0:0] rty1;
  logic [1:0] code1;
  logic       nack1, busy1, pronto1, erro1;

  config_manager_seq_uc #(.NUM_FIELDS(5), .MAX_RETRIES(2), .TIMEOUT_CYCLES(16)) dut0 (
    .clock(clock), .reset(reset),
    .receber_config(receber), .fim_recepcao_config(fim),
    .parity_config_ok(pok), .abort_config(abrt),
    .load_field(load0), .field_idx(idx0), .nack_config(nack0),
    .busy_config(busy0), .pronto_config(pronto0), .erro_config(erro0),
    .erro_code(code0), .retry_cnt(rty0)
  );

  config_manager_seq_uc #(.NUM_FIELDS(1), .MAX_RETRIES(0), .TIMEOUT_CYCLES(0)) dut1 (
    .clock(clock), .reset(reset),
    .receber_config(receber), .fim_recepcao_config(fim),
    .parity_config_ok(pok), .abort_config(abrt),
    .load_field(load1), .field_idx(idx1), .nack_config(nack1),
    .busy_config(busy1), .pronto_config(pronto1), .erro_config(erro1),
    .erro_code(code1), .retry_cnt(rty1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_chk;
  int n_fail;

  // Behavioural model: phase of the sequence plus plain integer counters.
  localparam int P_IDLE = 0, P_RX = 1, P_NK = 2, P_OK = 3, P_ER = 4;
  typedef struct {
    int ph;
    int idx;
    int rty;
    int tmr;
    int code;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mreset();
    mdl_t r;
    r.ph = P_IDLE; r.idx = 0; r.rty = 0; r.tmr = 0; r.code = 0;
    return r;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input int nf, input int mr, input int tmo,
                                 input bit s, input bit f, input bit p, input bit a);
    mdl_t n = m;
    if (m.ph == P_IDLE) begin
      if (s) begin
        n.ph = P_RX; n.idx = 0; n.rty = 0; n.tmr = 0; n.code = 0;
      end
    end else if (m.ph == P_RX) begin
      if (a) begin
        n.ph = P_ER; n.code = 3;
      end else if (f && p) begin
        if (m.idx == nf - 1) n.ph = P_OK;
        else begin n.idx = m.idx + 1; n.rty = 0; n.tmr = 0; end
      end else if (f) begin
        if (m.rty == mr) begin n.ph = P_ER; n.code = 1; end
        else begin n.ph = P_NK; n.rty = m.rty + 1; n.tmr = 0; end
      end else if (tmo != 0) begin
        if (m.tmr == tmo - 1) begin n.ph = P_ER; n.code = 2; end
        else n.tmr = m.tmr + 1;
      end
    end else if (m.ph == P_NK) begin
      if (a) begin n.ph = P_ER; n.code = 3; end
      else n.ph = P_RX;
    end else begin
      n.ph = P_IDLE;
    end
    return n;
  endfunction

  function automatic logic [31:0] mk(input logic [7:0] ld, input int idx, input int rty,
                                     input int code, input bit nk, input bit bz,
                                     input bit pr, input bit er);
    return {10'd0, ld, 4'(idx), 4'(rty), 2'(code), nk, bz, pr, er};
  endfunction

  function automatic logic [31:0] mpack(input mdl_t m);
    logic [7:0] ld;
    ld = (m.ph == P_RX) ? 8'(1 << m.idx) : 8'd0;
    return mk(ld, m.idx, m.rty, m.code, m.ph == P_NK, (m.ph == P_RX) || (m.ph == P_NK),
              (m.ph == P_OK) || (m.ph == P_ER), m.ph == P_ER);
  endfunction

  function automatic logic [31:0] obs0();
    return {10'd0, 8'(load0), 4'(idx0), 4'(rty0), code0, nack0, busy0, pronto0, erro0};
  endfunction

  function automatic logic [31:0] obs1();
    return {10'd0, 8'(load1), 4'(idx1), 4'(rty1), code1, nack1, busy1, pronto1, erro1};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, advance the models on the
  // rising edge, compare both instances at the next falling edge.
  task automatic tick(input bit s, input bit f, input bit p, input bit a);
    receber = s; fim = f; pok = p; abrt = a;
    @(posedge clock);
    if (!reset) begin
      m0 = mreset(); m1 = mreset();
    end else begin
      m0 = mstep(m0, 5, 2, 16, s, f, p, a);
      m1 = mstep(m1, 1, 0, 0, s, f, p, a);
    end
    @(negedge clock);
    check("model_nf5", obs0(), mpack(m0));
    check("model_nf1", obs1(), mpack(m1));
  endtask

  task automatic sync_reset();
    reset = 1'b0;
    m0 = mreset(); m1 = mreset();
    @(negedge clock);
    check("rst_nf5", obs0(), 32'd0);
    reset = 1'b1;
  endtask

  typedef struct {
    bit s, f, p, a;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit s, input bit f, input bit p, input bit a, input logic [7:0] ld,
                     input int idx, input int rty, input int code,
                     input bit nk, input bit bz, input bit pr, input bit er);
    vec_t v;
    v.s = s; v.f = f; v.p = p; v.a = a;
    v.exp = mk(ld, idx, rty, code, nk, bz, pr, er);
    tbl.push_back(v);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b0; receber = 0; fim = 0; pok = 0; abrt = 0;
    m0 = mreset(); m1 = mreset();

    //  s f p a  load   idx rty code nk bz pr er
    // field 2: two bad parities (one fim ignored in NACK), then complete
    add(1,0,0,0, 8'h01, 0, 0, 0,  0, 1, 0, 0);
    add(0,1,1,0, 8'h02, 1, 0, 0,  0, 1, 0, 0);
    add(0,1,1,0, 8'h04, 2, 0, 0,  0, 1, 0, 0);
    add(0,1,0,0, 8'h00, 2, 1, 0,  1, 1, 0, 0);
    add(0,1,1,0, 8'h04, 2, 1, 0,  0, 1, 0, 0);
    add(0,1,0,0, 8'h00, 2, 2, 0,  1, 1, 0, 0);
    add(0,0,0,0, 8'h04, 2, 2, 0,  0, 1, 0, 0);
    add(0,1,1,0, 8'h08, 3, 0, 0,  0, 1, 0, 0);
    add(0,1,1,0, 8'h10, 4, 0, 0,  0, 1, 0, 0);
    add(0,1,1,0, 8'h00, 4, 0, 0,  0, 0, 1, 0);
    add(0,0,0,0, 8'h00, 4, 0, 0,  0, 0, 0, 0);
    // field 1: three bad parities -> parity error
    add(1,0,0,0, 8'h01, 0, 0, 0,  0, 1, 0, 0);
    add(0,1,1,0, 8'h02, 1, 0, 0,  0, 1, 0, 0);
    add(0,1,0,0, 8'h00, 1, 1, 0,  1, 1, 0, 0);
    add(0,0,0,0, 8'h02, 1, 1, 0,  0, 1, 0, 0);
    add(0,1,0,0, 8'h00, 1, 2, 0,  1, 1, 0, 0);
    add(0,0,0,0, 8'h02, 1, 2, 0,  0, 1, 0, 0);
    add(0,1,0,0, 8'h00, 1, 2, 1,  0, 0, 1, 1);
    add(0,0,0,0, 8'h00, 1, 2, 1,  0, 0, 0, 0);
    add(0,0,0,1, 8'h00, 1, 2, 1,  0, 0, 0, 0);
    // abort during NACK (with fim present)
    add(1,0,0,0, 8'h01, 0, 0, 0,  0, 1, 0, 0);
    add(0,1,0,0, 8'h00, 0, 1, 0,  1, 1, 0, 0);
    add(0,1,1,1, 8'h00, 0, 1, 3,  0, 0, 1, 1);
    add(0,0,0,0, 8'h00, 0, 1, 3,  0, 0, 0, 0);
    // abort and fim together: abort wins; start ignored outside IDLE
    add(1,0,0,0, 8'h01, 0, 0, 0,  0, 1, 0, 0);
    add(0,1,1,1, 8'h00, 0, 0, 3,  0, 0, 1, 1);
    add(1,0,0,0, 8'h00, 0, 0, 3,  0, 0, 0, 0);
    add(1,0,0,0, 8'h01, 0, 0, 0,  0, 1, 0, 0);
    add(1,0,0,0, 8'h01, 0, 0, 0,  0, 1, 0, 0);

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("reset_nf5", obs0(), 32'd0);
    check("reset_nf1", obs1(), 32'd0);
    reset = 1'b1;

    foreach (tbl[i]) begin
      tick(tbl[i].s, tbl[i].f, tbl[i].p, tbl[i].a);
      check($sformatf("tbl[%0d]", i), obs0(), tbl[i].exp);
    end

    // Abort during field 3 (index 3)
    sync_reset();
    tick(1,0,0,0);
    for (int k = 0; k < 3; k++) tick(0,1,1,0);
    tick(0,0,0,0);
    check("pre_abort_f3", obs0(), mk(8'h08, 3, 0, 0, 0, 1, 0, 0));
    tick(0,0,0,1);
    check("abort_f3", obs0(), mk(8'h00, 3, 0, 3, 0, 0, 1, 1));
    tick(0,0,0,0);

    // Timeout with no fim: error on the 16th RECEIVE cycle
    tick(1,0,0,0);
    for (int k = 1; k < 16; k++) begin
      tick(0,0,0,0);
      check("tmo_wait", obs0(), mk(8'h01, 0, 0, 0, 0, 1, 0, 0));
    end
    tick(0,0,0,0);
    check("tmo_err", obs0(), mk(8'h00, 0, 0, 2, 0, 0, 1, 1));
    tick(0,0,0,0);
    check("tmo_hold", obs0(), mk(8'h00, 0, 0, 2, 0, 0, 0, 0));

    // fim on the timeout cycle wins; the next field gets a fresh timer
    tick(1,0,0,0);
    for (int k = 1; k < 16; k++) tick(0,0,0,0);
    tick(0,1,1,0);
    check("tmo_fim_wins", obs0(), mk(8'h02, 1, 0, 0, 0, 1, 0, 0));
    for (int k = 1; k < 16; k++) tick(0,0,0,0);
    check("tmo_fresh_wait", obs0(), mk(8'h02, 1, 0, 0, 0, 1, 0, 0));
    tick(0,0,0,0);
    check("tmo_err_f1", obs0(), mk(8'h00, 1, 0, 2, 0, 0, 1, 1));
    tick(0,0,0,0);

    // Five good fields, fim every third cycle
    tick(1,0,0,0);
    for (int i = 0; i < 5; i++) begin
      tick(0,0,0,0);
      tick(0,0,0,0);
      check("spaced_load", obs0(), mk(8'(1 << i), i, 0, 0, 0, 1, 0, 0));
      tick(0,1,1,0);
      if (i < 4) check("spaced_step", obs0(), mk(8'(1 << (i + 1)), i + 1, 0, 0, 0, 1, 0, 0));
      else       check("spaced_done", obs0(), mk(8'h00, 4, 0, 0, 0, 0, 1, 0));
    end
    tick(0,0,0,0);

    // Asynchronous reset in the middle of field 2
    tick(1,0,0,0);
    tick(0,1,1,0);
    tick(0,1,1,0);
    tick(0,0,0,0);
    #3;
    reset = 1'b0;
    #1;
    m0 = mreset(); m1 = mreset();
    check("async_rst_nf5", obs0(), 32'd0);
    check("async_rst_nf1", obs1(), 32'd0);
    @(negedge clock);
    check("rst_no_pronto", obs0(), 32'd0);
    reset = 1'b1;
    tick(1,0,0,0);
    check("restart", obs0(), mk(8'h01, 0, 0, 0, 0, 1, 0, 0));

    // Random traffic against the model, with occasional async resets
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 499) == 0) begin
        #2;
        reset = 1'b0;
        #1;
        m0 = mreset(); m1 = mreset();
        check("rand_rst", obs0(), 32'd0);
        @(negedge clock);
        reset = 1'b1;
      end
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) != 0, $urandom_range(0, 39) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/config_manager_seq_uc.md
Name: config_manager_seq_uc

Overview:
Parametrised control unit that sequences reception of NUM_FIELDS configuration fields (temperature thresholds, humidity limit, etc.) from the serial receiver into the configuration register bank. Drives a one-hot load vector and a field index to the datapath. Adds three capabilities over the fixed five-field sequencer:
- bounded parity-error retries with a retransmission request,
- a per-field reception timeout,
- an abort input with a coded error result.

Parameters:
NUM_FIELDS, 5, number of configuration fields received per sequence (>=1)
MAX_RETRIES, 2, parity-error retransmissions allowed per field (0 = fail on first bad parity)
TIMEOUT_CYCLES, 1000, clock cycles allowed per field before timeout (0 = timeout disabled)
IDX_W, $clog2(NUM_FIELDS) (min 1), width of field index
TMO_W, $clog2(TIMEOUT_CYCLES+1) (min 1), width of timeout counter

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
receber_config  input  1  start request, sampled only in IDLE
fim_recepcao_config  input  1  one-cycle pulse: current field fully received
parity_config_ok  input  1  parity of current field valid, qualified by fim_recepcao_config
abort_config  input  1  cancel sequence in progress
load_field  output  NUM_FIELDS  one-hot load enable; bit i = field i
field_idx  output  IDX_W  index of field currently being received
nack_config  output  1  one-cycle retransmission request after bad parity
busy_config  output  1  high in RECEIVE and NACK
pronto_config  output  1  one-cycle pulse at end of sequence (success or error)
erro_config  output  1  one-cycle pulse, coincident with pronto_config on error
erro_code  output  2  00 none, 01 parity, 10 timeout, 11 abort; held until next start
retry_cnt  output  2+  retries used on current field (width $clog2(MAX_RETRIES+1), min 1)

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; field_idx=0; retry_cnt=0; timer=0; erro_code=00.
  - All single-bit outputs 0; load_field=0.
- States: IDLE, RECEIVE, NACK, DONE, ERROR. Moore outputs from registered state and counters, so no combinational path from inputs to outputs.
- IDLE:
  - receber_config=1 -> RECEIVE next cycle.
  - On the same edge: field_idx=0, retry_cnt=0, timer=0, erro_code=00.
- RECEIVE:
  - load_field = one-hot(field_idx); busy_config=1.
  - timer increments each cycle; it does not increment when TIMEOUT_CYCLES=0.
  - Priority per cycle is abort > fim_recepcao_config > timeout.
  - abort_config=1 -> ERROR, erro_code=11.
  - fim=1, parity_ok=1, field_idx==NUM_FIELDS-1 -> DONE.
  - fim=1, parity_ok=1, other field_idx -> field_idx+1, retry_cnt=0, timer=0; stay in RECEIVE.
  - fim=1, parity_ok=0, retry_cnt==MAX_RETRIES -> ERROR, erro_code=01.
  - fim=1, parity_ok=0, retry_cnt<MAX_RETRIES -> NACK; retry_cnt+1; timer=0.
  - fim=0, TIMEOUT_CYCLES!=0, timer==TIMEOUT_CYCLES-1 -> ERROR, erro_code=10.
  - A fim pulse on the timeout cycle wins over the timeout.
- NACK:
  - Lasts exactly one cycle; nack_config=1, busy_config=1, load_field=0.
  - abort_config=1 -> ERROR, erro_code=11; otherwise -> RECEIVE at the same field_idx.
  - fim_recepcao_config in NACK is ignored.
- DONE: one cycle; pronto_config=1; -> IDLE.
- ERROR: one cycle; pronto_config=1, erro_config=1; -> IDLE.
- field_idx and retry_cnt hold their final values in IDLE until the next start.
- Ignored inputs:
  - receber_config outside IDLE has no effect.
  - abort_config in IDLE, DONE or ERROR has no effect.
- Latency:
  - Minimum successful sequence is 1 + NUM_FIELDS + 1 cycles from start acceptance to pronto, with fim on the first RECEIVE cycle of each field.
- Reset mid-sequence: immediate return to IDLE, no pronto or erro pulse.
- NUM_FIELDS=1: first good field -> DONE; field_idx is constant 0.
- Unreachable state encodings -> IDLE.

Test Plan:
- Defaults. Start, then 5 fim pulses with parity_ok=1, 3 cycles apart -> load_field steps 00001,00010,00100,01000,10000. pronto pulses 1 cycle after the 5th fim. erro_config=0, erro_code=00.
- Field 2 gets bad parity twice, then good -> nack_config pulses twice and retry_cnt reaches 2. Sequence then completes with erro_code=00. retry_cnt=0 on field 3.
- Field 1 gets bad parity 3 times (MAX_RETRIES=2) -> after the 3rd fim: ERROR, pronto=1, erro=1, erro_code=01, field_idx=1.
- TIMEOUT_CYCLES=16, no fim after start -> ERROR on cycle 16 of RECEIVE, erro_code=10. With fim on that same cycle and parity_ok=1 -> advances, no error.
- abort_config during field 3, and separately during NACK -> ERROR next cycle, erro_code=11. Both abort and fim in the same cycle -> abort wins.
- reset=0 asserted mid-field 2, asynchronous to clock -> outputs 0 immediately with no pronto. After release, receber_config starts a fresh sequence at field_idx=0.
